// File: rtl/sdram_arbiter_pkg.sv
// Shared types and defaults for the two-port SDRAM bus arbiter.
package sdram_arb_pkg;

  localparam int AW_DEF  = 21;
  localparam int TMO_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// One 16-bit SDRAM-style bus port: strobe/we/sel/word address/write data, read data/ack back.
interface sdram_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int AW = AW_DEF
) ();

  logic          stb;
  logic          we;
  logic [1:0]    sel;
  logic [AW:1]   adr;
  logic [15:0]   dat_w;
  logic [15:0]   dat_r;
  logic          ack;

  modport master (
    output stb, we, sel, adr, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  stb, we, sel, adr, dat_w,
    output dat_r, ack
  );

endinterface

// File: rtl/sdram_arbiter_rr_pick2.sv
// Two-requester round-robin picker: on a tie the requester not granted last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  always_comb begin
    valid = |req;
    if (req == 2'b11) gnt = ~last;
    else              gnt = req[1];
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin sharing of the SDRAM bus port between CPU (m0) and DMA (m1), with a
// forced idle stb cycle between transactions and a grant-to-ack timeout.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic            clk_p,
  input  logic            rst_n,
  sdram_arbiter_if.slave  m0,
  sdram_arbiter_if.slave  m1,
  sdram_arbiter_if.master s,
  input  logic            s_ready,
  output logic            tmo_err
);

  localparam int              CW       = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0]   TMO_LAST = CW'(TMO - 1);

  arb_state_e    state, nxt;
  logic          last;
  logic [CW-1:0] cnt;
  logic          pick_gnt, pick_valid;
  logic          arb_open, in_grant, grant_en, tmo_hit;
  logic          we_q;
  logic [1:0]    sel_q;
  logic [AW:1]   adr_q;
  logic [15:0]   dat_q;
  logic [15:0]   hold0, hold1;

  rr_pick2 u_pick (
    .req   ({m1.stb, m0.stb}),
    .last  (last),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  assign arb_open = (state == IDLE) || (state == GAP);
  assign in_grant = (state == G0) || (state == G1);
  assign grant_en = arb_open && s_ready && pick_valid;
  assign tmo_hit  = (cnt == TMO_LAST);

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, GAP: nxt = grant_en ? (pick_gnt ? G1 : G0) : IDLE;
      G0, G1:    if (s.ack || tmo_hit) nxt = GAP;
      default:   nxt = IDLE;
    endcase
  end

  // Request latch, round-robin history, saturating timeout counter and per-master read holds.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      last  <= 1'b1;
      cnt   <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (grant_en) begin
        last  <= pick_gnt;
        cnt   <= '0;
        we_q  <= pick_gnt ? m1.we    : m0.we;
        sel_q <= pick_gnt ? m1.sel   : m0.sel;
        adr_q <= pick_gnt ? m1.adr   : m0.adr;
        dat_q <= pick_gnt ? m1.dat_w : m0.dat_w;
      end else if (in_grant && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
      if ((state == G0) && s.ack) hold0 <= s.dat_r;
      if ((state == G1) && s.ack) hold1 <= s.dat_r;
    end
  end

  always_comb begin
    s.stb    = in_grant;
    s.we     = we_q;
    s.sel    = sel_q;
    s.adr    = adr_q;
    s.dat_w  = dat_q;
    m0.ack   = (state == G0) && s.ack;
    m1.ack   = (state == G1) && s.ack;
    m0.dat_r = (state == G0) ? s.dat_r : hold0;
    m1.dat_r = (state == G1) ? s.dat_r : hold1;
    tmo_err  = in_grant && tmo_hit && !s.ack;
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small SDRAM ack model of programmable latency.
module tb_sdram_arbiter;

  logic clk_p = 1'b0;
  logic rst_n;
  logic s_ready;
  logic tmo_err;

  always #5 clk_p = ~clk_p;

  sdram_arbiter_if #(.AW(21)) m0_if ();
  sdram_arbiter_if #(.AW(21)) m1_if ();
  sdram_arbiter_if #(.AW(21)) s_if ();

  sdram_arbiter #(.AW(21), .TMO(16)) dut (
    .clk_p   (clk_p),
    .rst_n   (rst_n),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if),
    .s_ready (s_ready),
    .tmo_err (tmo_err)
  );

  int          total = 0;
  int          bad   = 0;
  int          ack_lat = 0;
  logic [15:0] rd_data = 16'h1234;
  int          mdl_cnt = 0;

  // SDRAM model: acks in the ack_lat-th stb-high cycle; ack_lat == 0 never acks.
  always @(posedge clk_p) begin
    #1;
    s_if.dat_r = rd_data;
    if (!s_if.stb || s_if.ack) begin
      mdl_cnt   = 0;
      s_if.ack  = 1'b0;
    end else begin
      mdl_cnt++;
      if ((ack_lat != 0) && (mdl_cnt == ack_lat)) s_if.ack = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          n0, n1, ntmo, nack, hi, low, nb, ack_at, done;
  logic        prev;
  logic [15:0] dat_seen;
  logic [20:0] own [4];
  int          gap [4];

  initial begin
    rst_n   = 1'b0;
    s_ready = 1'b1;
    m0_if.stb = 1'b0; m0_if.we = 1'b0; m0_if.sel = 2'b00; m0_if.adr = '0; m0_if.dat_w = '0;
    m1_if.stb = 1'b0; m1_if.we = 1'b0; m1_if.sel = 2'b00; m1_if.adr = '0; m1_if.dat_w = '0;
    repeat (3) @(negedge clk_p);

    chk("rst_s_stb",  s_if.stb,    1'b0);
    chk("rst_s_we",   s_if.we,     1'b0);
    chk("rst_s_sel",  s_if.sel,    2'b00);
    chk("rst_s_adr",  s_if.adr,    21'h0);
    chk("rst_s_out",  s_if.dat_w,  16'h0);
    chk("rst_m0_dat", m0_if.dat_r, 16'h0);
    chk("rst_m1_dat", m1_if.dat_r, 16'h0);
    chk("rst_m0_ack", m0_if.ack,   1'b0);
    chk("rst_m1_ack", m1_if.ack,   1'b0);
    chk("rst_tmo",    tmo_err,     1'b0);
    rst_n = 1'b1;
    @(negedge clk_p);
    chk("idle_stb", s_if.stb, 1'b0);

    // Single read by m0, model acks in the 5th stb cycle
    ack_lat = 5; rd_data = 16'h1234;
    m0_if.stb = 1'b1; m0_if.we = 1'b0; m0_if.sel = 2'b11; m0_if.adr = 21'h001000;
    @(negedge clk_p);
    chk("rd_stb_latency", s_if.stb, 1'b1);
    chk("rd_sel", s_if.sel, 2'b11);
    chk("rd_we",  s_if.we,  1'b0);
    chk("rd_adr", s_if.adr, 21'h001000);
    m0_if.stb = 1'b0;
    n0 = 0; n1 = 0; ack_at = -1; dat_seen = '0;
    for (int i = 0; i < 20; i++) begin
      if (m0_if.ack) begin n0++; ack_at = i; dat_seen = m0_if.dat_r; end
      if (m1_if.ack) n1++;
      @(negedge clk_p);
    end
    chk("rd_m0_ack_count", n0, 1);
    chk("rd_ack_cycle",    ack_at, 4);
    chk("rd_dat_at_ack",   dat_seen, 16'h1234);
    chk("rd_m1_no_ack",    n1, 0);
    chk("rd_m0_dat_hold",  m0_if.dat_r, 16'h1234);
    chk("rd_m1_dat_hold",  m1_if.dat_r, 16'h0);

    // Contention: m0 was granted last, so m1 leads the alternation
    ack_lat = 3;
    m0_if.stb = 1'b1; m0_if.adr = 21'h000111;
    m1_if.stb = 1'b1; m1_if.we = 1'b0; m1_if.sel = 2'b11; m1_if.adr = 21'h000222;
    nb = 0; low = 0; prev = 1'b0;
    for (int i = 0; i < 4; i++) begin own[i] = '0; gap[i] = -1; end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_p);
      if (s_if.stb && !prev) begin
        if (nb < 4) begin own[nb] = s_if.adr; gap[nb] = low; end
        nb++;
        low = 0;
      end
      if (!s_if.stb) low++;
      prev = s_if.stb;
    end
    chk("rr_own0", own[0], 21'h000222);
    chk("rr_own1", own[1], 21'h000111);
    chk("rr_own2", own[2], 21'h000222);
    chk("rr_own3", own[3], 21'h000111);
    chk("rr_gap1", gap[1], 1);
    chk("rr_gap2", gap[2], 1);
    chk("rr_gap3", gap[3], 1);
    m0_if.stb = 1'b0; m1_if.stb = 1'b0;
    repeat (10) @(negedge clk_p);
    chk("rr_drain_stb", s_if.stb, 1'b0);

    // Byte write by m1; inputs change mid-grant but the latched request must not
    ack_lat = 6;
    m1_if.stb = 1'b1; m1_if.we = 1'b1; m1_if.sel = 2'b10; m1_if.adr = 21'h00ABCD; m1_if.dat_w = 16'hBEEF;
    @(negedge clk_p);
    chk("wr_stb", s_if.stb,   1'b1);
    chk("wr_we",  s_if.we,    1'b1);
    chk("wr_sel", s_if.sel,   2'b10);
    chk("wr_adr", s_if.adr,   21'h00ABCD);
    chk("wr_out", s_if.dat_w, 16'hBEEF);
    m1_if.stb = 1'b0; m1_if.we = 1'b0; m1_if.sel = 2'b01; m1_if.adr = 21'h015555; m1_if.dat_w = 16'h0000;
    repeat (2) @(negedge clk_p);
    chk("wr_hold_stb", s_if.stb,   1'b1);
    chk("wr_hold_we",  s_if.we,    1'b1);
    chk("wr_hold_sel", s_if.sel,   2'b10);
    chk("wr_hold_adr", s_if.adr,   21'h00ABCD);
    chk("wr_hold_out", s_if.dat_w, 16'hBEEF);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 10; i++) begin
      if (m0_if.ack) n0++;
      if (m1_if.ack) n1++;
      @(negedge clk_p);
    end
    chk("wr_m1_ack_count", n1, 1);
    chk("wr_m0_no_ack",    n0, 0);

    // Timeout: never acked, 16 stb cycles, one tmo_err, one gap, then re-grant
    ack_lat = 0;
    m0_if.stb = 1'b1; m0_if.we = 1'b0; m0_if.sel = 2'b11; m0_if.adr = 21'h003000;
    hi = 0; low = 0; ntmo = 0; nack = 0; nb = 0; done = 0; prev = 1'b0;
    for (int i = 0; (i < 60) && (done == 0); i++) begin
      @(negedge clk_p);
      if (tmo_err) ntmo++;
      if (m0_if.ack || m1_if.ack) nack++;
      if (s_if.stb && !prev) begin
        nb++;
        if (nb == 2) done = 1;
      end
      if ((nb == 1) && s_if.stb)  hi++;
      if ((nb == 1) && !s_if.stb) low++;
      prev = s_if.stb;
    end
    chk("tmo_regrant",  done, 1);
    chk("tmo_stb_len",  hi,   16);
    chk("tmo_gap",      low,  1);
    chk("tmo_err_once", ntmo, 1);
    chk("tmo_no_ack",   nack, 0);
    m0_if.stb = 1'b0;
    repeat (20) @(negedge clk_p);
    chk("tmo_drain_stb", s_if.stb, 1'b0);

    // Ack on the terminal-count cycle: ack wins, no tmo_err
    ack_lat = 16;
    m0_if.stb = 1'b1;
    @(negedge clk_p);
    m0_if.stb = 1'b0;
    hi = 0; ntmo = 0; n0 = 0;
    for (int i = 0; i < 25; i++) begin
      if (s_if.stb) hi++;
      if (tmo_err) ntmo++;
      if (m0_if.ack) n0++;
      @(negedge clk_p);
    end
    chk("tie_stb_len", hi,   16);
    chk("tie_ack",     n0,   1);
    chk("tie_no_tmo",  ntmo, 0);

    // Not ready blocks grants; a grant already running completes when ready drops
    ack_lat = 2;
    s_ready = 1'b0;
    m0_if.stb = 1'b1; m0_if.adr = 21'h004000;
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_p);
      if (s_if.stb) hi++;
    end
    chk("nrdy_no_stb", hi, 0);
    s_ready = 1'b1;
    @(negedge clk_p);
    chk("nrdy_grant", s_if.stb, 1'b1);
    m0_if.stb = 1'b0;
    s_ready = 1'b0;
    n0 = 0;
    for (int i = 0; i < 6; i++) begin
      if (m0_if.ack) n0++;
      @(negedge clk_p);
    end
    chk("nrdy_completes", n0, 1);
    chk("nrdy_idle_stb",  s_if.stb, 1'b0);
    s_ready = 1'b1;

    // Reset mid-grant: stb drops with no edge; afterwards m0 wins the first tie again
    ack_lat = 8;
    m0_if.stb = 1'b1; m0_if.adr = 21'h000111;
    m1_if.stb = 1'b1; m1_if.adr = 21'h000222;
    @(negedge clk_p);
    chk("rst_pre_owner", s_if.adr, 21'h000222);
    @(negedge clk_p);
    #2 rst_n = 1'b0;
    #1;
    chk("rstg_stb",    s_if.stb,  1'b0);
    chk("rstg_m0_ack", m0_if.ack, 1'b0);
    chk("rstg_m1_ack", m1_if.ack, 1'b0);
    chk("rstg_adr",    s_if.adr,  21'h0);
    @(negedge clk_p);
    rst_n = 1'b1;
    @(negedge clk_p);
    chk("rstg_regrant", s_if.stb, 1'b1);
    chk("rstg_tie_m0",  s_if.adr, 21'h000111);
    m0_if.stb = 1'b0; m1_if.stb = 1'b0;
    repeat (15) @(negedge clk_p);
    chk("end_idle_stb", s_if.stb, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port round-robin arbiter that shares the single SDRAM bus port (stb/we/sel/adr/out/dat/ack, word address [21:1]) between the CPU bus and a DMA master, such as the disk controllers. It sits between `topboard`'s requesters and the board-level SDRAM controller glue. It latches each granted request, guarantees at least one idle `stb` cycle between transactions (the SDRAM glue latches byte masks on the `stb` rising edge and needs its ack pipeline drained), and flags requests that never complete.

## Interface
- `AW`, 21: top bit of the word address; the address bus is `[AW:1]`.
- `TMO`, 255: grant-to-ack timeout in clocks (1..65535).

- `clk_p`  in  1  100 MHz core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m0_stb`, `m0_we`  in  1  CPU request strobe and write flag.
- `m0_sel`  in  2  CPU byte enables, [1] high byte, [0] low byte.
- `m0_adr`  in  AW  CPU word address `[AW:1]`.
- `m0_dat_i`  in  16  CPU write data.
- `m0_dat_o`  out  16  CPU read data.
- `m0_ack`  out  1  CPU transfer done.
- `m1_stb`, `m1_we`, `m1_sel`, `m1_adr`, `m1_dat_i`, `m1_dat_o`, `m1_ack`: DMA port, same as m0.
- `s_stb`, `s_we`  out  1  to SDRAM port.
- `s_sel`  out  2  to SDRAM port.
- `s_adr`  out  AW  to SDRAM port.
- `s_out`  out  16  to SDRAM port.
- `s_dat`  in  16  SDRAM read data.
- `s_ack`  in  1  SDRAM ack; only meaningful while `s_stb` is high.
- `s_ready`  in  1  SDRAM init done.
- `tmo_err`  out  1  one-cycle pulse when a transaction is aborted.

## Operation
- **States:** IDLE, G0, G1, GAP.
- **IDLE:** if `s_ready` is high and any `mN_stb` is high, register that master's we/sel/adr/dat_i into the `s_*` regs and go to G0 or G1. If `s_ready` is low, stay in IDLE.
- **Round-robin:** if both masters request, grant the master not granted last. A `last` register updates on every grant. After reset `last` is 1, so m0 wins the first tie.
- **G0/G1:**
  - `s_stb` is 1.
  - `mN_ack` = `s_ack` AND grant==N, combinational.
  - `mN_dat_o` = `s_dat` for the granted master, and holds the last granted value otherwise.
  - On `s_ack`, go to GAP.
  - If the timeout counter reaches TMO-1 without `s_ack`, go to GAP, pulse `tmo_err`, and do not assert any ack. The requester stays pending and is re-arbitrated.
- **GAP:** `s_stb` is 0 for exactly one cycle. Arbitration runs as in IDLE, so back-to-back grants are possible. With no requests, go to IDLE.
- Master signals are ignored after the latch. A master that drops `stb` mid-grant still completes; its ack is discarded by the master.
- `s_ready` falling during a grant does not abort the transaction. It only blocks new grants.

## Timing
- **Reset values:**
  - `s_stb`, `s_we`, `m0_ack`, `m1_ack`, `tmo_err` = 0.
  - `s_sel` = 2'b00; `s_adr`, `s_out`, `m0_dat_o`, `m1_dat_o` = 0.
  - State = IDLE, `last` = 1, timeout counter = 0.
- Asserting `rst_n` low mid-grant drops `s_stb` immediately and asynchronously. No ack is issued.
- **Latency:** `mN_stb` sampled at edge k causes `s_stb` = 1 from edge k+1. `mN_ack` appears in the same cycle as `s_ack`.
- **Minimum spacing:** one low cycle of `s_stb` between transactions. Best-case throughput is one transfer per (SDRAM latency + 1) clocks.
- Timeout counter: width ceil(log2(TMO)), cleared on every grant, saturating.
- Simultaneous `s_ack` and timeout terminal count: the ack wins and no `tmo_err` is raised.

## Structure
- Shared package `sdram_arb_pkg` holds:
  - the state enum (IDLE, G0, G1, GAP);
  - `AW_DEF` = 21;
  - `TMO_DEF` = 255.
- One natural sub-module: `rr_pick2`, a two-requester round-robin picker (req[1:0], last → gnt, valid), combinational.
- FSM, latch registers and the timeout counter live in the top module.

## Test plan
- **Single read:** m0 reads adr 0x001000; the SDRAM model acks 5 cycles after `s_stb`. Expect `m0_ack` for 1 cycle with `m0_dat_o` = model data 0x1234, `s_sel` = 2'b11, `s_we` = 0, and `m1_ack` never asserted.
- **Contention:** both masters hold `stb` continuously. Expect grants alternating m0,m1,m0,m1, each `s_stb` burst separated by exactly 1 low cycle.
- **Byte write:** m1 writes sel 2'b10, adr 0x0ABCD, data 0xBEEF. Expect `s_sel` = 2'b10, `s_out` = 0xBEEF, `s_adr` = 0x0ABCD, all latched and unchanged even if m1 changes inputs mid-grant.
- **Timeout:** TMO = 16 and the model never acks. Expect `s_stb` to drop after 16 cycles, `tmo_err` to pulse once, and no ack. The master is re-granted after the GAP cycle.
- **Not ready:** `s_ready` = 0 while m0 requests. Expect `s_stb` to stay 0. Raising `s_ready` gives `s_stb` = 1 on the next edge.
- **Reset mid-grant:** pull `rst_n` low while `s_stb` = 1. Expect `s_stb` = 0 with no clock edge and no ack. After release, the first tie goes to m0.
